// File: rtl/nonce_scheduler.sv
// -----------------------------------------------------------------------------
// nonce_scheduler
//
// Purpose
//   Drives an external hash core through a linear nonce search. When a search
//   starts, the block latches a 96-bit header template and an 8-bit
//   difficulty. It then launches the core once per nonce, with the nonce
//   spliced into the low NONCE_W bits of the header. It stops at the first
//   nonce whose hash[23:16] is below the difficulty, when the nonce space is
//   exhausted, or when the core fails to answer within TIMEOUT cycles.
//
//   Per-nonce schedule (L = cycles from core_start to core_done):
//     LAUNCH (1 cycle) -> WAIT (L cycles) -> CHECK (1 cycle) -> LAUNCH ...
//   so each nonce occupies L+2 cycles.
//
// Parameters
//   NONCE_W   width of the nonce field, replaces bloque_bytes[NONCE_W-1:0] (4..32)
//   TIMEOUT   core_done watchdog budget per nonce (>= 2)
//
// Ports
//   clk           in   single clock, rising edge
//   reset         in   asynchronous, active-high reset
//   inicio        in   start request, honoured in IDLE and DONE
//   cancelar      in   abort; returns to IDLE from any non-IDLE state
//   bloque_bytes  in   96-bit header template
//   target        in   difficulty; hash accepted when hash[23:16] < target
//   core_start    out  one-cycle launch pulse to the hash core
//   core_bloque   out  {latched header[95:NONCE_W], nonce}
//   core_done     in   one-cycle completion pulse from the hash core
//   core_hash     in   hash result, valid only with core_done
//   ocupado       out  search in progress
//   terminado     out  search has ended (level, held in DONE)
//   encontrado    out  a valid nonce was found
//   error         out  watchdog expired
//   nonce_out     out  current / last nonce tried
//   hash          out  last captured core_hash
// -----------------------------------------------------------------------------
module nonce_scheduler #(
    parameter int NONCE_W = 16,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inicio,
    input  logic               cancelar,
    input  logic [95:0]        bloque_bytes,
    input  logic [7:0]         target,
    output logic               core_start,
    output logic [95:0]        core_bloque,
    input  logic               core_done,
    input  logic [23:0]        core_hash,
    output logic               ocupado,
    output logic               terminado,
    output logic               encontrado,
    output logic               error,
    output logic [NONCE_W-1:0] nonce_out,
    output logic [23:0]        hash
);

    // Watchdog counts WAIT cycles without core_done. It must be able to hold
    // TIMEOUT-1, the value it reaches on expiry.
    localparam int WD_W = $clog2(TIMEOUT);

    // The counter is cleared in LAUNCH and is 0 in the first WAIT cycle. Expiry
    // is taken in the WAIT cycle whose increment would make it TIMEOUT-1. That
    // gives TIMEOUT-1 WAIT cycles, and DONE follows TIMEOUT cycles after the
    // core_start cycle.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 2);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        CHECK,
        DONE
    } state_t;

    state_t state_q, state_d;

    // Only the header bits above the nonce field are kept. The nonce register
    // supplies the low bits of core_bloque.
    logic [95:NONCE_W]  hdr_q;
    logic [7:0]         target_q;
    logic [NONCE_W-1:0] nonce_q;
    logic [23:0]        hash_q;
    logic [WD_W-1:0]    wd_q;
    logic               encontrado_q;
    logic               error_q;

    // Control strobes from the FSM to the datapath.
    logic load_job;
    logic clr_wd;
    logic inc_wd;
    logic cap_hash;
    logic inc_nonce;
    logic set_found;
    logic set_err;
    logic clr_flags;

    logic hash_hit;

    // Unsigned compare. target_q = 0 can never be exceeded, so a zero target
    // always leads to exhaustion without extra logic.
    assign hash_hit = (hash_q[23:16] < target_q);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            // NOTE: registers use non-blocking assignments. Every flop then
            // samples the pre-edge value of the others, whatever the
            // statement order.
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and control decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first. No
        // branch can leave one unassigned, so no latch is inferred.
        state_d   = state_q;
        load_job  = 1'b0;
        clr_wd    = 1'b0;
        inc_wd    = 1'b0;
        cap_hash  = 1'b0;
        inc_nonce = 1'b0;
        set_found = 1'b0;
        set_err   = 1'b0;
        clr_flags = 1'b0;

        // Abort wins over start, completion and watchdog expiry in the same
        // cycle.
        if (cancelar && (state_q != IDLE)) begin
            state_d   = IDLE;
            clr_flags = 1'b1;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (inicio) begin
                        state_d  = LAUNCH;
                        load_job = 1'b1;
                    end
                end

                LAUNCH: begin
                    state_d = WAIT;
                    clr_wd  = 1'b1;
                end

                WAIT: begin
                    if (core_done) begin
                        cap_hash = 1'b1;
                        state_d  = CHECK;
                    end else begin
                        inc_wd = 1'b1;
                        if (wd_q == WD_LAST) begin
                            set_err = 1'b1;
                            state_d = DONE;
                        end
                    end
                end

                CHECK: begin
                    if (hash_hit) begin
                        set_found = 1'b1;
                        state_d   = DONE;
                    end else if (&nonce_q) begin
                        // Last nonce tried without success: stop here rather
                        // than wrap back to 0.
                        state_d = DONE;
                    end else begin
                        inc_nonce = 1'b1;
                        state_d   = LAUNCH;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hdr_q        <= '0;
            target_q     <= '0;
            nonce_q      <= '0;
            hash_q       <= '0;
            wd_q         <= '0;
            encontrado_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            // The header and target change only here, on a start from IDLE or
            // DONE. That keeps core_bloque stable for the whole search.
            if (load_job) begin
                hdr_q        <= bloque_bytes[95:NONCE_W];
                target_q     <= target;
                nonce_q      <= '0;
                encontrado_q <= 1'b0;
                error_q      <= 1'b0;
            end

            if (clr_wd) begin
                wd_q <= '0;
            end else if (inc_wd) begin
                wd_q <= wd_q + 1'b1;
            end

            if (cap_hash) begin
                hash_q <= core_hash;
            end

            if (inc_nonce) begin
                nonce_q <= nonce_q + 1'b1;
            end

            if (set_found) begin
                encontrado_q <= 1'b1;
            end

            if (set_err) begin
                error_q <= 1'b1;
            end

            if (clr_flags) begin
                encontrado_q <= 1'b0;
                error_q      <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // The status outputs are decoded from the state register. They therefore
    // fall to 0 as soon as the asynchronous reset forces IDLE.
    assign core_start  = (state_q == LAUNCH);
    assign ocupado     = (state_q == LAUNCH) || (state_q == WAIT) || (state_q == CHECK);
    assign terminado   = (state_q == DONE);
    assign encontrado  = encontrado_q;
    assign error       = error_q;
    assign nonce_out   = nonce_q;
    assign hash        = hash_q;
    assign core_bloque = {hdr_q, nonce_q};

endmodule

// File: tb/tb_nonce_scheduler.sv
// -----------------------------------------------------------------------------
// tb_nonce_scheduler
//
// Directed bench for nonce_scheduler (NONCE_W=4, TIMEOUT=8) with a behavioural
// hash core of fixed latency. Each scenario first pushes the core_bloque
// values it expects on successive core_start pulses into a queue. The core
// model logs every pulse. At the end of each scenario the queue is drained
// against that log.
// -----------------------------------------------------------------------------
module tb_nonce_scheduler;

    localparam int NW  = 4;
    localparam int TO  = 8;
    localparam int LAT = 3;

    localparam logic [95:0] HDR1 = 96'h0123_4567_89AB_CDEF_0011_223A;
    localparam logic [95:0] HDR2 = 96'hFEDC_BA98_7654_3210_A5A5_5A5B;
    localparam logic [95:0] HDR3 = 96'h1357_9BDF_2468_ACE0_C0DE_BEEC;

    logic          clk = 1'b0;
    logic          reset;
    logic          inicio;
    logic          cancelar;
    logic [95:0]   bloque_bytes;
    logic [7:0]    target;
    logic          core_start;
    logic [95:0]   core_bloque;
    logic          core_done = 1'b0;
    logic [23:0]   core_hash = 24'h0;
    logic          ocupado;
    logic          terminado;
    logic          encontrado;
    logic          error;
    logic [NW-1:0] nonce_out;
    logic [23:0]   hash;

    nonce_scheduler #(
        .NONCE_W (NW),
        .TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .inicio       (inicio),
        .cancelar     (cancelar),
        .bloque_bytes (bloque_bytes),
        .target       (target),
        .core_start   (core_start),
        .core_bloque  (core_bloque),
        .core_done    (core_done),
        .core_hash    (core_hash),
        .ocupado      (ocupado),
        .terminado    (terminado),
        .encontrado   (encontrado),
        .error        (error),
        .nonce_out    (nonce_out),
        .hash         (hash)
    );

    always #5 clk = ~clk;

    // Free-running cycle count, used to timestamp core_start pulses.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference hash: hash[23:16] is 0x10 at the chosen nonce and 0xFF
    // elsewhere. The low bits tag the nonce so captured values are traceable.
    function automatic logic [23:0] hash_of(input logic [NW-1:0] n, input int m);
        hash_of = {((int'(n) == m) ? 8'h10 : 8'hFF), 8'hC3, 4'h5, n};
    endfunction

    function automatic logic [95:0] blk(input logic [95:0] h, input logic [NW-1:0] n);
        blk = {h[95:NW], n};
    endfunction

    // ---------------------------------------------------------------- core model
    logic          core_en  = 1'b0;   // set by the stimulus: core answers when 1
    int            match_at = 99;     // set by the stimulus: nonce that hits
    int            start_cnt = 0;
    logic [95:0]   obs_bloque [0:127];
    int            obs_cyc    [0:127];
    int            arm_cnt = 0;
    logic [NW-1:0] arm_nonce = '0;
    int            arm_match = 99;

    always @(negedge clk) begin
        core_done = 1'b0;
        core_hash = 24'h5A5A5A;
        if (arm_cnt > 0) begin
            arm_cnt = arm_cnt - 1;
            if (arm_cnt == 0) begin
                core_done = 1'b1;
                core_hash = hash_of(arm_nonce, arm_match);
            end
        end
        if (core_start === 1'b1) begin
            if (start_cnt < 128) begin
                obs_bloque[start_cnt] = core_bloque;
                obs_cyc[start_cnt]    = cyc;
            end
            start_cnt = start_cnt + 1;
            if (core_en) begin
                arm_cnt   = LAT;
                arm_nonce = core_bloque[NW-1:0];
                arm_match = match_at;
            end
        end
    end

    // ---------------------------------------------------------------- checking
    int          checks   = 0;
    int          failures = 0;
    logic [95:0] exp_q [$];
    int          rd_ptr = 0;
    int          base   = 0;
    int          n      = 0;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drain_sb(input string tag);
        logic [95:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rd_ptr < start_cnt && rd_ptr < 128)
                check(tag, obs_bloque[rd_ptr], e);
            else
                check({tag, "_missing_pulse"}, 96'(start_cnt), 96'(rd_ptr + 1));
            rd_ptr++;
        end
        check({tag, "_pulse_count"}, 96'(start_cnt), 96'(rd_ptr));
        rd_ptr = start_cnt;
    endtask

    task automatic do_start(input logic [95:0] h, input logic [7:0] t);
        @(negedge clk);
        bloque_bytes = h;
        target       = t;
        inicio       = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
    endtask

    task automatic wait_term(input int budget, output int cnt);
        cnt = 0;
        while (terminado !== 1'b1 && cnt < budget) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        reset        = 1'b0;
        inicio       = 1'b0;
        cancelar     = 1'b0;
        bloque_bytes = '0;
        target       = '0;

        // ---- reset state, applied before any clock edge
        #1 reset = 1'b1;
        #1;
        check("rst_core_start", 96'(core_start), 96'(0));
        check("rst_status", 96'({ocupado, terminado, encontrado, error}), 96'(0));
        check("rst_nonce_hash", 96'({nonce_out, hash}), 96'(0));
        check("rst_core_bloque", core_bloque, 96'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // ---- found at nonce 5, L=3, target 0x20
        core_en  = 1'b1;
        match_at = 5;
        for (int i = 0; i < 6; i++) exp_q.push_back(blk(HDR1, NW'(i)));
        base = start_cnt;
        do_start(HDR1, 8'h20);
        check("b_first_start", 96'(core_start), 96'(1));
        check("b_ocupado_run", 96'(ocupado), 96'(1));
        wait_term(200, n);
        repeat (3) @(negedge clk);
        check("b_terminado", 96'(terminado), 96'(1));
        check("b_encontrado", 96'(encontrado), 96'(1));
        check("b_error", 96'(error), 96'(0));
        check("b_ocupado_done", 96'(ocupado), 96'(0));
        check("b_nonce_out", 96'(nonce_out), 96'(5));
        check("b_hash_hi", 96'(hash[23:16]), 96'(8'h10));
        check("b_hash", 96'(hash), 96'(hash_of(NW'(5), 5)));
        check("b_first_to_last", 96'(obs_cyc[base + 5] - obs_cyc[base]), 96'(5 * (LAT + 2)));
        drain_sb("b_bloque");

        // ---- target 0: exhaust all 16 nonces, no wrap
        match_at = 5;
        for (int i = 0; i < 16; i++) exp_q.push_back(blk(HDR2, NW'(i)));
        do_start(HDR2, 8'h00);
        check("c_terminado_cleared", 96'(terminado), 96'(0));
        wait_term(200, n);
        repeat (8) @(negedge clk);
        check("c_terminado", 96'(terminado), 96'(1));
        check("c_encontrado", 96'(encontrado), 96'(0));
        check("c_error", 96'(error), 96'(0));
        check("c_nonce_out", 96'(nonce_out), 96'(4'hF));
        check("c_hash", 96'(hash), 96'(hash_of(NW'(15), 5)));
        drain_sb("c_bloque");

        // ---- watchdog: core never answers
        core_en = 1'b0;
        exp_q.push_back(blk(HDR3, NW'(0)));
        do_start(HDR3, 8'h20);
        check("d_core_start", 96'(core_start), 96'(1));
        wait_term(20, n);
        check("d_latency_le_timeout", 96'(n <= TO), 96'(1));
        check("d_terminado", 96'(terminado), 96'(1));
        check("d_error", 96'(error), 96'(1));
        check("d_encontrado", 96'(encontrado), 96'(0));
        check("d_ocupado", 96'(ocupado), 96'(0));
        repeat (2) @(negedge clk);
        drain_sb("d_bloque");

        // ---- cancel in WAIT of nonce 2, core answers two cycles later
        core_en  = 1'b1;
        match_at = 15;
        for (int i = 0; i < 3; i++) exp_q.push_back(blk(HDR1, NW'(i)));
        do_start(HDR1, 8'h00);
        n = 0;
        while (!(core_start === 1'b1 && nonce_out == NW'(2)) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("e_reached_n2", 96'({core_start, nonce_out}), 96'({1'b1, 4'd2}));
        @(negedge clk);
        cancelar = 1'b1;
        @(negedge clk);
        cancelar = 1'b0;
        check("e_cancel_idle", 96'({ocupado, terminado, core_start}), 96'(0));
        @(negedge clk);
        #1;
        check("e_late_done_present", 96'(core_done), 96'(1));
        @(negedge clk);
        check("e_hash_kept", 96'(hash), 96'(hash_of(NW'(1), 15)));
        check("e_flags_idle", 96'({ocupado, terminado, encontrado, error}), 96'(0));
        repeat (3) @(negedge clk);
        drain_sb("e_bloque");
        match_at = 1;
        exp_q.push_back(blk(HDR2, NW'(0)));
        exp_q.push_back(blk(HDR2, NW'(1)));
        do_start(HDR2, 8'h20);
        check("e_restart_nonce", 96'(nonce_out), 96'(0));
        check("e_restart_bloque", core_bloque, blk(HDR2, NW'(0)));
        wait_term(100, n);
        check("e_restart_found", 96'({terminado, encontrado, nonce_out}), 96'({1'b1, 1'b1, 4'd1}));
        repeat (2) @(negedge clk);
        drain_sb("e_restart_bloque");

        // ---- inicio during WAIT is ignored; inicio in DONE restarts
        match_at = 1;
        exp_q.push_back(blk(HDR3, NW'(0)));
        exp_q.push_back(blk(HDR3, NW'(1)));
        do_start(HDR3, 8'h20);
        @(negedge clk);
        bloque_bytes = HDR1;
        target       = 8'h00;
        inicio       = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        check("f_bloque_held", core_bloque, blk(HDR3, NW'(0)));
        wait_term(100, n);
        check("f_found_with_old_target", 96'({terminado, encontrado, nonce_out}), 96'({1'b1, 1'b1, 4'd1}));
        check("f_done_bloque", core_bloque, blk(HDR3, NW'(1)));
        exp_q.push_back(blk(HDR1, NW'(0)));
        exp_q.push_back(blk(HDR1, NW'(1)));
        do_start(HDR1, 8'h20);
        check("f_terminado_cleared", 96'(terminado), 96'(0));
        check("f_new_bloque", core_bloque, blk(HDR1, NW'(0)));
        wait_term(100, n);
        check("f_second_found", 96'({terminado, encontrado}), 96'({1'b1, 1'b1}));
        repeat (2) @(negedge clk);
        drain_sb("f_bloque");

        // ---- reset between edges in WAIT
        core_en = 1'b0;
        exp_q.push_back(blk(HDR2, NW'(0)));
        do_start(HDR2, 8'h20);
        @(negedge clk);
        check("g_in_wait", 96'(ocupado), 96'(1));
        #2 reset = 1'b1;
        #1;
        check("g_async_status", 96'({core_start, ocupado, terminado, encontrado, error, nonce_out, hash}), 96'(0));
        check("g_async_bloque", core_bloque, 96'(0));
        @(negedge clk);
        check("g_held_idle", 96'({core_start, ocupado, terminado}), 96'(0));
        reset        = 1'b0;
        core_en      = 1'b1;
        match_at     = 0;
        bloque_bytes = HDR3;
        target       = 8'h20;
        inicio       = 1'b1;
        exp_q.push_back(blk(HDR3, NW'(0)));
        @(negedge clk);
        inicio = 1'b0;
        check("g_first_edge_start", 96'(core_start), 96'(1));
        wait_term(100, n);
        check("g_found", 96'({terminado, encontrado, error, nonce_out}), 96'({1'b1, 1'b1, 1'b0, 4'd0}));
        repeat (2) @(negedge clk);
        drain_sb("g_bloque");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
